// File: rtl/bin2bcd_iter.sv
// bin2bcd_iter: sequential double-dabble binary-to-BCD converter, one bit per clock
module bin2bcd_iter #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_a,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_overflow
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t              r_state;
    logic [WIDTH-1:0]    r_bin;
    logic [4*DIGITS-1:0] r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_ovf;
    logic                r_busy;
    logic                r_valid;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_overflow;
    logic [4*DIGITS-1:0] w_adj;
    logic [4*DIGITS:0]   w_shift;
    logic                w_ovf;
    // per-digit add-3 correction; digits never carry into each other
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign w_adj[4*g+:4] = (r_acc[4*g+:4] >= 4'd5) ? r_acc[4*g+:4] + 4'd3 : r_acc[4*g+:4];
    end
    // top bit of w_shift is the bit lost off the accumulator, which flags overflow
    assign w_shift = {w_adj, r_bin[WIDTH-1]};
    assign w_ovf   = r_ovf | w_shift[4*DIGITS];
    // conversion FSM; results are published only on the final shift edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_bin      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (i_start) begin
                    r_bin   <= i_a;
                    r_acc   <= '0;
                    r_ovf   <= 1'b0;
                    r_cnt   <= CW'(WIDTH);
                    r_busy  <= 1'b1;
                    r_state <= SHIFT;
                end
            end else begin
                r_acc <= w_shift[4*DIGITS-1:0];
                r_bin <= r_bin << 1;
                r_ovf <= w_ovf;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    r_bcd      <= w_shift[4*DIGITS-1:0];
                    r_overflow <= w_ovf;
                    r_valid    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            end
        end
    end
    assign o_busy     = r_busy;
    assign o_valid    = r_valid;
    assign o_bcd      = r_bcd;
    assign o_overflow = r_overflow;
endmodule

// File: tb/tb_bin2bcd_iter.sv
// tb_bin2bcd_iter: directed checks of bin2bcd_iter in 14/4, 8/3 and 8/2 configurations
module tb_bin2bcd_iter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  st;
    logic [13:0] a_in;
    logic [2:0]  vld, bsy, ov;
    logic [15:0] bcd0;
    logic [11:0] bcd1;
    logic [7:0]  bcd2;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    bin2bcd_iter #(.WIDTH(14), .DIGITS(4)) u0 (.i_clk(clk), .i_rst_n(rst_n), .i_start(st[0]), .i_a(a_in),
        .o_busy(bsy[0]), .o_valid(vld[0]), .o_bcd(bcd0), .o_overflow(ov[0]));
    bin2bcd_iter #(.WIDTH(8), .DIGITS(3)) u1 (.i_clk(clk), .i_rst_n(rst_n), .i_start(st[1]), .i_a(a_in[7:0]),
        .o_busy(bsy[1]), .o_valid(vld[1]), .o_bcd(bcd1), .o_overflow(ov[1]));
    bin2bcd_iter #(.WIDTH(8), .DIGITS(2)) u2 (.i_clk(clk), .i_rst_n(rst_n), .i_start(st[2]), .i_a(a_in[7:0]),
        .o_busy(bsy[2]), .o_valid(vld[2]), .o_bcd(bcd2), .o_overflow(ov[2]));

    function automatic logic [15:0] get_bcd(input int idx);
        return (idx == 0) ? bcd0 : (idx == 1) ? {4'h0, bcd1} : {8'h00, bcd2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // accept one operand on DUT idx, wait (bounded) for VALID; lat counts edges after accept
    task automatic run(input int idx, input logic [13:0] a, output int lat, output int nbusy);
        a_in = a;
        st[idx] = 1'b1;
        tick();
        st[idx] = 1'b0;
        lat = 0;
        nbusy = int'(bsy[idx]);
        while (!vld[idx] && lat < 40) begin
            tick();
            lat++;
            nbusy += int'(bsy[idx]);
        end
    endtask

    task automatic conv(input string tag, input int idx, input logic [13:0] a, input int exp_lat,
                        input logic [15:0] exp_bcd, input logic exp_ov);
        int lat, nbusy;
        run(idx, a, lat, nbusy);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, nbusy, exp_lat);
        chk({tag, "_bcd"}, get_bcd(idx), exp_bcd);
        chk({tag, "_ovf"}, ov[idx], exp_ov);
        chk({tag, "_busy_at_valid"}, bsy[idx], 1'b0);
        tick();
        chk({tag, "_valid_drop"}, vld[idx], 1'b0);
        chk({tag, "_bcd_hold"}, get_bcd(idx), exp_bcd);
    endtask

    initial begin
        int nv, first, second, third;
        rst_n = 1'b0;
        st = '0;
        a_in = '0;
        tick();
        chk("rst_busy", bsy[0], 1'b0);
        chk("rst_valid", vld[0], 1'b0);
        chk("rst_bcd", bcd0, 16'h0000);
        chk("rst_ovf", ov[0], 1'b0);
        rst_n = 1'b1;
        tick();
        conv("c9999", 0, 14'd9999, 14, 16'h9999, 1'b0);
        conv("c16383", 0, 14'd16383, 14, 16'h6383, 1'b1);
        conv("c0", 0, 14'd0, 14, 16'h0000, 1'b0);
        // START during a conversion must be ignored
        a_in = 14'd1234;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        nv = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                a_in = 14'd42;
                st[0] = 1'b1;
            end else st[0] = 1'b0;
            tick();
            if (vld[0]) nv++;
        end
        chk("ign_bcd", bcd0, 16'h1234);
        chk("ign_pulses", nv, 1);
        // START held high: one result every WIDTH+1 cycles
        a_in = 14'd7;
        st[0] = 1'b1;
        nv = 0;
        first = -1;
        second = -1;
        third = -1;
        for (int i = 0; i <= 46; i++) begin
            tick();
            if (vld[0]) begin
                nv++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
                else third = i;
            end
            if (i == 20 || i == 35) chk("hold_bcd_between", bcd0, 16'h0007);
        end
        st[0] = 1'b0;
        chk("hold_pulses", nv, 3);
        chk("hold_first", first, 14);
        chk("hold_gap1", second - first, 15);
        chk("hold_gap2", third - second, 15);
        chk("hold_bcd", bcd0, 16'h0007);
        for (int i = 0; i < 20 && bsy[0]; i++) tick();
        chk("hold_drained", bsy[0], 1'b0);
        tick();
        // asynchronous reset mid-conversion
        a_in = 14'd500;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_busy_pre", bsy[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bsy[0], 1'b0);
        chk("mid_rst_valid", vld[0], 1'b0);
        chk("mid_rst_bcd", bcd0, 16'h0000);
        chk("mid_rst_ovf", ov[0], 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        conv("c321", 0, 14'd321, 14, 16'h0321, 1'b0);
        conv("w8d3_255", 1, 14'd255, 8, 16'h0255, 1'b0);
        conv("w8d2_255", 2, 14'd255, 8, 16'h0055, 1'b1);
        conv("w8d2_99", 2, 14'd99, 8, 16'h0099, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
